// File: rtl/fseq_pkg.sv
// Shared types and default configuration for the Filter_2 frame sequencer.
// The optional VBLANK watchdog is enabled by defining FSEQ_TIMEOUT_EN.
package fseq_pkg;

  localparam int unsigned FSEQ_DATA_WIDTH  = 8;
  localparam int unsigned FSEQ_WIDTH_IMAG  = 4;
  localparam int unsigned FSEQ_HEIGHT_IMAG = 4;
  localparam int unsigned FSEQ_H_BLANK     = 2;
  localparam int unsigned FSEQ_V_BLANK     = 8;
  localparam int unsigned FSEQ_DST_BASE    = 16;
  localparam int unsigned FSEQ_ADDR_W      = 8;
  localparam int unsigned FSEQ_TIMEOUT_CYC = 64;
  localparam int unsigned NPIX             = FSEQ_WIDTH_IMAG * FSEQ_HEIGHT_IMAG;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LINE   = 3'd1,
    ST_HBLANK = 3'd2,
    ST_VBLANK = 3'd3,
    ST_DONE   = 3'd4
  } fseq_state_e;

  // Bits needed for a counter spanning 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fseq_result_writer.sv
// Captures the filter result stream into the destination SRAM region,
// dropping anything outside the capture window or beyond one frame of results.
module fseq_result_writer
  import fseq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FSEQ_DATA_WIDTH,
  parameter int unsigned ADDR_W     = FSEQ_ADDR_W,
  parameter int unsigned PIX_CNT    = NPIX,
  parameter int unsigned DST_BASE   = FSEQ_DST_BASE
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  i_clear,
  input  logic                  i_capture,
  input  logic                  i_f_wr,
  input  logic [DATA_WIDTH-1:0] i_f_data,
  output logic                  o_wr_en,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_complete_c
);

  localparam int unsigned RES_W = cnt_w(PIX_CNT + 1);

  logic [RES_W-1:0]      r_res_cnt;
  logic                  r_wr_en;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  w_accept;

  assign w_accept     = i_f_wr & i_capture & (r_res_cnt < RES_W'(PIX_CNT));
  assign o_complete_c = (r_res_cnt == RES_W'(PIX_CNT));
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;

  // One-cycle registered write port; address follows the result index.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_res_cnt <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (i_clear) begin
        r_res_cnt <= '0;
      end else if (w_accept) begin
        r_res_cnt <= r_res_cnt + RES_W'(1);
        r_wr_addr <= ADDR_W'(DST_BASE) + ADDR_W'(r_res_cnt);
        r_wr_data <= i_f_data;
      end
    end
  end

endmodule

// File: rtl/filter_frame_sequencer.sv
// Streams one frame from the source SRAM through Filter_2 with hav/vav blanking
// and stores the results. Define FSEQ_TIMEOUT_EN to add the VBLANK watchdog.
module filter_frame_sequencer
  import fseq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = FSEQ_DATA_WIDTH,
  parameter int unsigned WIDTH_IMAG  = FSEQ_WIDTH_IMAG,
  parameter int unsigned HEIGHT_IMAG = FSEQ_HEIGHT_IMAG,
  parameter int unsigned H_BLANK     = FSEQ_H_BLANK,
  parameter int unsigned V_BLANK     = FSEQ_V_BLANK,
  parameter int unsigned DST_BASE    = FSEQ_DST_BASE,
  parameter int unsigned ADDR_W      = FSEQ_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = FSEQ_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  o_hav,
  output logic                  o_vav,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  f_wr,
  input  logic [DATA_WIDTH-1:0] f_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned PIX_CNT = WIDTH_IMAG * HEIGHT_IMAG;
  localparam int unsigned COL_W   = cnt_w(WIDTH_IMAG);
  localparam int unsigned ROW_W   = cnt_w(HEIGHT_IMAG);
  localparam int unsigned HB_W    = cnt_w(H_BLANK);
  localparam int unsigned VB_MAX  = (V_BLANK > TIMEOUT_CYC) ? V_BLANK : TIMEOUT_CYC;
  localparam int unsigned VB_W    = cnt_w(VB_MAX + 1);

  fseq_state_e       r_state, w_state_nxt;
  logic [COL_W-1:0]  r_col, w_col_nxt;
  logic [ROW_W-1:0]  r_row, w_row_nxt;
  logic [HB_W-1:0]   r_hb_cnt, w_hb_nxt;
  logic [VB_W-1:0]   r_vb_cnt, w_vb_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic              r_busy, r_done, r_rd_en, r_hav, r_vav;
  logic              w_start_acc, w_capture, w_complete;
`ifdef FSEQ_TIMEOUT_EN
  logic              r_err, w_err_nxt;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign o_hav   = r_hav;
  assign o_vav   = r_vav;
  assign o_data  = rd_data;

  // Results are only captured while a frame is actually in flight.
  assign w_capture = (r_state == ST_LINE) || (r_state == ST_HBLANK) || (r_state == ST_VBLANK);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_hb_nxt      = r_hb_cnt;
    w_vb_nxt      = r_vb_cnt;
    w_rd_addr_nxt = r_rd_addr;
    w_start_acc   = 1'b0;
`ifdef FSEQ_TIMEOUT_EN
    w_err_nxt     = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_LINE;
          w_col_nxt     = '0;
          w_row_nxt     = '0;
          w_rd_addr_nxt = '0;
          w_start_acc   = 1'b1;
`ifdef FSEQ_TIMEOUT_EN
          w_err_nxt     = 1'b0;
`endif
        end
      end
      ST_LINE: begin
        // rd_addr runs linearly through the frame; the HBLANK hold keeps it at the next row start.
        w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        if (r_col == COL_W'(WIDTH_IMAG - 1)) begin
          w_state_nxt = ST_HBLANK;
          w_col_nxt   = '0;
          w_hb_nxt    = '0;
        end else begin
          w_col_nxt = r_col + COL_W'(1);
        end
      end
      ST_HBLANK: begin
        if (r_hb_cnt == HB_W'(H_BLANK - 1)) begin
          if (r_row == ROW_W'(HEIGHT_IMAG - 1)) begin
            w_state_nxt = ST_VBLANK;
            w_vb_nxt    = '0;
          end else begin
            w_state_nxt = ST_LINE;
            w_row_nxt   = r_row + ROW_W'(1);
          end
        end else begin
          w_hb_nxt = r_hb_cnt + HB_W'(1);
        end
      end
      ST_VBLANK: begin
        if (r_vb_cnt != VB_W'(VB_MAX)) w_vb_nxt = r_vb_cnt + VB_W'(1);
        if (w_complete && (r_vb_cnt >= VB_W'(V_BLANK))) begin
          w_state_nxt = ST_DONE;
`ifdef FSEQ_TIMEOUT_EN
        end else if (!w_complete && (r_vb_cnt >= VB_W'(TIMEOUT_CYC - 1))) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
`endif
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters and registered outputs; hav/vav decode the current state so they line up with rd_data.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_col     <= '0;
      r_row     <= '0;
      r_hb_cnt  <= '0;
      r_vb_cnt  <= '0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_hav     <= 1'b0;
      r_vav     <= 1'b0;
    end else begin
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_hb_cnt  <= w_hb_nxt;
      r_vb_cnt  <= w_vb_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      r_rd_en   <= (w_state_nxt == ST_LINE);
      r_hav     <= (r_state == ST_LINE);
      r_vav     <= (r_state == ST_LINE) || (r_state == ST_HBLANK);
    end
  end

`ifdef FSEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_err <= 1'b0;
    else       r_err <= w_err_nxt;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  fseq_result_writer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W),
    .PIX_CNT    (PIX_CNT),
    .DST_BASE   (DST_BASE)
  ) u_writer (
    .clk          (clk),
    .rstb         (rstb),
    .i_clear      (w_start_acc),
    .i_capture    (w_capture),
    .i_f_wr       (f_wr),
    .i_f_data     (f_data),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_complete_c (w_complete)
  );

endmodule
